// File: rtl/pipeline_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipeline_ctrl.
interface pipeline_ctrl_if;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned STALL_W = 32;
  localparam int unsigned FLUSH_W = 16;

  // Datapath status seen by the controller
  logic [REG_W-1:0]   IFID_RS1;
  logic [REG_W-1:0]   IFID_RS2;
  logic               IDEX_MemRead;
  logic [REG_W-1:0]   IDEX_RD;
  logic               EXMEM_Branch_Taken;
  logic               EXMEM_MemAccess;
  logic               dmem_ready;

  // Controller decisions and observability
  logic               PC_Write;
  logic               IFID_Write;
  logic               IFID_Flush;
  logic               IDEX_Flush;
  logic               EXMEM_Flush;
  logic               MEMWB_Flush;
  logic               Pipe_Hold;
  logic [STATE_W-1:0] state;
  logic               mem_timeout;
  logic [STALL_W-1:0] stall_count;
  logic [FLUSH_W-1:0] flush_count;

  // Datapath side: supplies status, consumes controls
  modport master (
    output IFID_RS1, IFID_RS2, IDEX_MemRead, IDEX_RD,
           EXMEM_Branch_Taken, EXMEM_MemAccess, dmem_ready,
    input  PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush,
           MEMWB_Flush, Pipe_Hold, state, mem_timeout, stall_count, flush_count
  );

  // Controller side
  modport slave (
    input  IFID_RS1, IFID_RS2, IDEX_MemRead, IDEX_RD,
           EXMEM_Branch_Taken, EXMEM_MemAccess, dmem_ready,
    output PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush,
           MEMWB_Flush, Pipe_Hold, state, mem_timeout, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: memory-wait stall with timeout, branch flush,
// load-use interlock, plus stall/flush event counters.
module pipeline_ctrl (
  input  logic          clk,
  input  logic          reset,
  pipeline_ctrl_if.slave bus
);
  localparam int unsigned WAIT_W  = 8;
  localparam int unsigned STALL_W = 32;
  localparam int unsigned FLUSH_W = 16;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                timeout_q, timeout_d;
  logic [STALL_W-1:0]  stall_cnt_q;
  logic [FLUSH_W-1:0]  flush_cnt_q;

  logic mem_stall;
  logic eval_run;
  logic load_use;
  logic pc_write_c, ifid_write_c;
  logic ifid_flush_c, idex_flush_c, exmem_flush_c, memwb_flush_c;
  logic pipe_hold_c;

  // Load-use hazard: EX-stage load writes a register the ID instruction reads
  assign load_use = bus.IDEX_MemRead && (bus.IDEX_RD != 5'd0) &&
                    ((bus.IDEX_RD == bus.IFID_RS1) || (bus.IDEX_RD == bus.IFID_RS2));

  // Next-state and zero-latency control decode
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_d     = timeout_q;
    mem_stall     = 1'b0;
    eval_run      = 1'b0;
    pc_write_c    = 1'b1;
    ifid_write_c  = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_flush_c = 1'b0;
    memwb_flush_c = 1'b0;
    pipe_hold_c   = 1'b0;

    case (state_q)
      RUN: begin
        eval_run = 1'b1;
        if (bus.EXMEM_MemAccess && !bus.dmem_ready) begin
          mem_stall  = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (!bus.dmem_ready) begin
          mem_stall = 1'b1;
          if (wait_cnt_q == 8'hFF) begin
            state_d   = HALT;
            timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else begin
          // Memory finished: behave like RUN with the memory condition met
          eval_run = 1'b1;
          state_d  = RUN;
        end
      end
      HALT: begin
        mem_stall = 1'b1;
      end
      default: begin
        eval_run = 1'b1;
        state_d  = RUN;
      end
    endcase

    if (mem_stall) begin
      pc_write_c    = 1'b0;
      ifid_write_c  = 1'b0;
      pipe_hold_c   = 1'b1;
      memwb_flush_c = 1'b1;
    end else if (eval_run) begin
      if (bus.EXMEM_Branch_Taken) begin
        ifid_flush_c  = 1'b1;
        idex_flush_c  = 1'b1;
        exmem_flush_c = 1'b1;
      end else if (load_use) begin
        pc_write_c   = 1'b0;
        ifid_write_c = 1'b0;
        idex_flush_c = 1'b1;
      end
    end
  end

  // State, wait counter, sticky timeout and event counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      if (!pc_write_c && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (exmem_flush_c) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign bus.PC_Write    = pc_write_c;
  assign bus.IFID_Write  = ifid_write_c;
  assign bus.IFID_Flush  = ifid_flush_c;
  assign bus.IDEX_Flush  = idex_flush_c;
  assign bus.EXMEM_Flush = exmem_flush_c;
  assign bus.MEMWB_Flush = memwb_flush_c;
  assign bus.Pipe_Hold   = pipe_hold_c;
  assign bus.state       = 2'(state_q);
  assign bus.mem_timeout = timeout_q;
  assign bus.stall_count = stall_cnt_q;
  assign bus.flush_count = flush_cnt_q;
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have: clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have: IFID_RS1, IFID_RS2  in  5 each  source registers of the instruction in ID.
REQ-004 SHALL have: IDEX_MemRead  in  1, IDEX_RD  in  5  load flag and destination of the instruction in EX.
REQ-005 SHALL have: EXMEM_Branch_Taken  in  1  branch or jump resolved taken in MEM.
REQ-006 SHALL have: EXMEM_MemAccess  in  1  load or store in MEM; dmem_ready  in  1  data memory done this cycle.
REQ-007 SHALL have: PC_Write, IFID_Write  out  1 each  register enables, 1 = update.
REQ-008 SHALL have: IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Flush  out  1 each  load a bubble (zero controls) next edge.
REQ-009 SHALL have: Pipe_Hold  out  1  freezes ID/EX and EX/MEM contents.
REQ-010 SHALL have: state  out  2, mem_timeout  out  1 (sticky), stall_count  out  32, flush_count  out  16.

Function
REQ-011 SHALL implement FSM states: RUN=2'b00, MEM_WAIT=2'b01, HALT=2'b10; 2'b11 SHALL go to RUN.
REQ-012 SHALL drive control outputs combinationally from current state and inputs, zero-latency.
REQ-013 Defaults: PC_Write=1, IFID_Write=1, all flushes 0, Pipe_Hold=0.
REQ-014 Memory stall: in RUN with EXMEM_MemAccess=1 and dmem_ready=0 -> PC_Write=0, IFID_Write=0, Pipe_Hold=1, MEMWB_Flush=1, no other flush; next state MEM_WAIT; wait_cnt (8-bit) cleared to 0.
REQ-015 In MEM_WAIT with dmem_ready=0 -> same outputs as REQ-014; wait_cnt increments by 1.
REQ-016 In MEM_WAIT with dmem_ready=0 and wait_cnt==255 -> next state HALT, mem_timeout set to 1.
REQ-017 In MEM_WAIT with dmem_ready=1 -> evaluated exactly as RUN with memory condition satisfied (REQ-018/019 apply); next state RUN.
REQ-018 Branch flush: EXMEM_Branch_Taken=1 (memory condition satisfied) -> IFID_Flush=1, IDEX_Flush=1, EXMEM_Flush=1, PC_Write=1, IFID_Write=1.
REQ-019 Load-use: no branch flush, IDEX_MemRead=1, IDEX_RD!=0, IDEX_RD equal to IFID_RS1 or IFID_RS2 -> PC_Write=0, IFID_Write=0, IDEX_Flush=1.
REQ-020 Priority: memory stall > branch flush > load-use > defaults.
REQ-021 HALT: PC_Write=0, IFID_Write=0, Pipe_Hold=1, MEMWB_Flush=1, ignores all inputs, exits only by reset.
REQ-022 stall_count SHALL increment each edge where PC_Write=0, saturating at 32'hFFFFFFFF.
REQ-023 flush_count SHALL increment each edge where EXMEM_Flush=1, wrapping 16'hFFFF -> 0.
REQ-024 state output SHALL equal the current FSM state register.

Reset
REQ-025 On reset assertion, asynchronously: state=RUN, wait_cnt=0, mem_timeout=0, stall_count=0, flush_count=0.
REQ-026 During reset, outputs SHALL show RUN evaluation of inputs; no counter or state update occurs.
REQ-027 Reset mid-MEM_WAIT or in HALT SHALL return to RUN with no residual wait_cnt.

Verification
REQ-028 Load-use: IDEX_MemRead=1, IDEX_RD=5, IFID_RS2=5 -> PC_Write=0, IFID_Write=0, IDEX_Flush=1; stall_count 0->1 after edge; IDEX_RD=0 same regs -> no stall.
REQ-029 Branch over load-use: Branch_Taken=1 plus REQ-028 inputs -> three front flushes, PC_Write=1, flush_count +1.
REQ-030 Memory wait: MemAccess=1, dmem_ready low 3 cycles then high -> state 01 for 3 cycles, Pipe_Hold=1 and MEMWB_Flush=1 during them, RUN after ready edge, stall_count=3.
REQ-031 Timeout: MemAccess=1, dmem_ready held 0 -> HALT after 257 edges, mem_timeout=1, state=2'b10 until reset.
REQ-032 Wrap/saturate: 65536 branch flushes -> flush_count=0; reset asserted mid-MEM_WAIT between edges -> state=00, counters 0 immediately.
